dotmatrix_rx: RTL
=================

Name: dotmatrix_rx

Overview:
- Receiver/capture end of the dot-matrix serial display interface (RCLK, RSDI, CSDI, CCLK, LE, OEB) driven by the pong core.
- Emulates the row and column shift-register drivers. Oversamples all six lines in the system clock domain and deserializes one display line per LE pulse.
- Presents the decoded line as parallel data plus row index. Used for in-bench display checking and for bridging to other display back-ends.

Parameters:
- COLS, 32, number of column bits shifted per line (CSDI/CCLK chain length).
- ROWS, 16, number of rows in the one-hot row chain (RSDI/RCLK).
- RIDX_W, $clog2(ROWS), width of row_index.

Ports:
- clk  input  1  system clock, ≥3x faster than fastest RCLK/CCLK/LE toggle rate
- reset  input  1  asynchronous, active-low reset
- RCLK  input  1  row shift clock, rising-edge active
- RSDI  input  1  row serial data
- CSDI  input  1  column serial data
- CCLK  input  1  column shift clock, rising-edge active
- LE  input  1  column latch enable, rising-edge captures line
- OEB  input  1  output enable, active-low
- col_data  output  COLS  latched column bits; bit COLS-1 = first bit shifted after previous latch
- row_index  output  RIDX_W  binary index of the set bit in the row chain at latch time
- row_err  output  1  row chain not exactly one-hot at latch time
- len_err  output  1  CCLK edge count since previous latch != COLS
- line_valid  output  1  one-cycle strobe: col_data/row_index/row_err/len_err updated
- frame_count  output  8  count of latches with row_index==0 and row_err==0; wraps 255->0
- blank  output  1  synchronized OEB (1 = display dark)

Behaviour:
- Reset (reset=0, async):
  - col_data=0, row_index=0, row_err=0, len_err=0, line_valid=0, frame_count=0, blank=1.
  - Internal column and row shift regs = 0; edge counter = 0.
  - Synchronizer flops: 0, except OEB flops = 1.
- Synchronization:
  - Each input passes through 2 flops (s1, s2).
  - A third flop s3 on RCLK, CCLK and LE gives edge detect: rise = s2 & ~s3.
  - Data sampled = s2 value of RSDI/CSDI in the rise cycle.
  - Requirement on driver: every level and data setup/hold ≥2 clk cycles around each edge. Narrower pulses are not supported and may be missed.
- Latency: input rising edge to the register update it causes = 3 clk cycles. blank follows OEB with 2 clk cycles latency.
- Column chain, on CCLK rise:
  - col_sr <= {col_sr[COLS-2:0], csdi}.
  - col_cnt <= col_cnt+1, saturating at COLS+1.
- Row chain, on RCLK rise: row_sr <= {row_sr[ROWS-2:0], rsdi}.
- LE rise (one cycle of work):
  - col_data <= col_sr; row_index <= lowest set bit position of row_sr (0 if none).
  - row_err <= (popcount(row_sr) != 1); len_err <= (col_cnt != COLS).
  - col_cnt <= 0; line_valid=1 in the following cycle only.
  - If row_sr==one-hot bit 0 then frame_count <= frame_count+1.
- Simultaneous events in the same clk cycle:
  - CCLK rise + LE rise: the shift is applied first and the latch captures the post-shift value. col_cnt includes that edge, then clears to 0.
  - RCLK rise + LE rise: row decode uses the post-shift row_sr.
  - RCLK and CCLK together: independent, both applied.
- Other rules:
  - Shifting continues regardless of OEB; blank has no effect on capture.
  - col_cnt saturates, so len_err stays 1 for any overlong line and never wraps to a false match.
  - Back-to-back LE pulses with no CCLK give col_data unchanged, len_err=1.
  - Reset mid-line discards partial shifts. The first latch after reset reports len_err unless exactly COLS bits were shifted after reset.
- No other state machine: the block is a continuous shift/latch datapath plus an edge-counter FSM (col_cnt).

Test Plan:
- Reset: hold reset=0 with all inputs toggling, then release -> all outputs at reset values, blank=1, no line_valid for 10 cycles with LE idle.
- Nominal line: shift RSDI=1 then 4 zeros (row bit 4 set), shift 32 CSDI bits 0xA5C3_0F81 MSB first, pulse LE -> exactly one line_valid 3 cycles after LE rise, col_data=0xA5C30F81, row_index=4, row_err=0, len_err=0.
- Length error: 31 CCLK edges then LE -> len_err=1. Then 40 edges then LE -> len_err=1. Then 32 edges then LE -> len_err=0.
- Row error: row_sr all zero -> row_err=1, row_index=0. Two bits set (bits 2,5) -> row_err=1, row_index=2. frame_count unchanged in both cases.
- Frame count: 256 latches with a valid row 0 -> frame_count returns to 0. Row 1..15 latches in between -> no increment.
- Coincidence/blank: CCLK and LE rising on the same clk edge after 31 prior bits -> len_err=0, col_data includes the 32nd bit. OEB low then high -> blank 0 then 1, each 2 cycles after the input change.

Source files
------------

// File: rtl/dotmatrix_rx_if.sv
// Dot-matrix display serial bus plus decoded-line outputs.
// Driver side holds the six serial lines; receiver side returns the decoded line.
interface dotmatrix_rx_if #(
  parameter int COLS   = 32,
  parameter int ROWS   = 16,
  parameter int RIDX_W = $clog2(ROWS)
);
  logic              RCLK;
  logic              RSDI;
  logic              CSDI;
  logic              CCLK;
  logic              LE;
  logic              OEB;
  logic [COLS-1:0]   col_data;
  logic [RIDX_W-1:0] row_index;
  logic              row_err;
  logic              len_err;
  logic              line_valid;
  logic [7:0]        frame_count;
  logic              blank;

  modport master (
    output RCLK, RSDI, CSDI, CCLK, LE, OEB,
    input  col_data, row_index, row_err, len_err,
    input  line_valid, frame_count, blank
  );

  modport slave (
    input  RCLK, RSDI, CSDI, CCLK, LE, OEB,
    output col_data, row_index, row_err, len_err,
    output line_valid, frame_count, blank
  );
endinterface

// File: rtl/dotmatrix_rx.sv
// Dot-matrix display receiver: oversamples the serial lines,
// emulates row/column shift chains and captures one line per LE.
module dotmatrix_rx #(
  parameter int COLS   = 32,
  parameter int ROWS   = 16,
  parameter int RIDX_W = $clog2(ROWS)
) (
  input logic          clk,
  input logic          reset,
  dotmatrix_rx_if.slave bus
);

  localparam int CNT_W = $clog2(COLS + 2);
  localparam int POP_W = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COLS + 1);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(COLS);

  localparam int I_RCLK = 0;
  localparam int I_RSDI = 1;
  localparam int I_CSDI = 2;
  localparam int I_CCLK = 3;
  localparam int I_LE   = 4;
  localparam int I_OEB  = 5;

  localparam logic [5:0] SYNC_RST = 6'b100000;

  logic [5:0] in_w;
  logic [5:0] s1_q;
  logic [5:0] s2_q;
  logic [2:0] s3_q;

  logic rclk_rise;
  logic cclk_rise;
  logic le_rise;

  logic [COLS-1:0]   col_sr_q;
  logic [COLS-1:0]   col_sr_d;
  logic [CNT_W-1:0]  col_cnt_q;
  logic [CNT_W-1:0]  col_cnt_d;
  logic [CNT_W-1:0]  col_cnt_sh;
  logic [ROWS-1:0]   row_sr_q;
  logic [ROWS-1:0]   row_sr_d;

  logic [COLS-1:0]   col_data_q;
  logic [RIDX_W-1:0] row_index_q;
  logic              row_err_q;
  logic              len_err_q;
  logic              line_valid_q;
  logic [7:0]        frame_q;

  logic [RIDX_W-1:0] low_idx;
  logic [POP_W-1:0]  pop;
  logic              one_hot;
  logic              row0_hit;

  assign in_w = {bus.OEB, bus.LE, bus.CCLK,
                 bus.CSDI, bus.RSDI, bus.RCLK};

  // Two-flop synchronizers on every line, third flop on the clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= SYNC_RST;
      s2_q <= SYNC_RST;
      s3_q <= '0;
    end else begin
      s1_q <= in_w;
      s2_q <= s1_q;
      s3_q <= {s2_q[I_LE], s2_q[I_CCLK], s2_q[I_RCLK]};
    end
  end

  assign rclk_rise = s2_q[I_RCLK] & ~s3_q[0];
  assign cclk_rise = s2_q[I_CCLK] & ~s3_q[1];
  assign le_rise   = s2_q[I_LE]   & ~s3_q[2];

  // Shift first, so a coincident LE captures the post-shift chains.
  always_comb begin
    col_sr_d   = col_sr_q;
    col_cnt_sh = col_cnt_q;
    row_sr_d   = row_sr_q;
    if (cclk_rise) begin
      col_sr_d = {col_sr_q[COLS-2:0], s2_q[I_CSDI]};
      if (col_cnt_q != CNT_MAX) begin
        col_cnt_sh = col_cnt_q + CNT_W'(1);
      end
    end
    if (rclk_rise) begin
      row_sr_d = {row_sr_q[ROWS-2:0], s2_q[I_RSDI]};
    end
    col_cnt_d = le_rise ? '0 : col_cnt_sh;
  end

  // Lowest set bit and population count of the row chain.
  always_comb begin
    low_idx = '0;
    pop     = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (row_sr_d[i]) begin
        low_idx = RIDX_W'(i);
      end
      pop = pop + POP_W'(row_sr_d[i]);
    end
    one_hot  = (pop == POP_W'(1));
    row0_hit = one_hot & row_sr_d[0];
  end

  // Shift chains and the saturating column edge counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_sr_q  <= '0;
      col_cnt_q <= '0;
      row_sr_q  <= '0;
    end else begin
      col_sr_q  <= col_sr_d;
      col_cnt_q <= col_cnt_d;
      row_sr_q  <= row_sr_d;
    end
  end

  // Line capture on LE rise, strobe and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_data_q   <= '0;
      row_index_q  <= '0;
      row_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      line_valid_q <= 1'b0;
      frame_q      <= '0;
    end else begin
      line_valid_q <= le_rise;
      if (le_rise) begin
        col_data_q  <= col_sr_d;
        row_index_q <= low_idx;
        row_err_q   <= ~one_hot;
        len_err_q   <= (col_cnt_sh != CNT_LEN);
        if (row0_hit) begin
          frame_q <= frame_q + 8'd1;
        end
      end
    end
  end

  assign bus.col_data    = col_data_q;
  assign bus.row_index   = row_index_q;
  assign bus.row_err     = row_err_q;
  assign bus.len_err     = len_err_q;
  assign bus.line_valid  = line_valid_q;
  assign bus.frame_count = frame_q;
  assign bus.blank       = s2_q[I_OEB];

endmodule
